// File: rtl/mic_frame_ctrl_if.sv
// Purpose : bundles the FIFO-read, mic-side and downstream sample signals of mic_frame_ctrl.
// Ports   : master = controller view (drives fifo_rd_en, out_*, busy, frame_cnt, sticky flags);
//           slave  = environment view (drives enable, mic_wr, FIFO flags/data, out_ready, clr_overflow).
interface mic_frame_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              enable;
  logic              mic_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              overflow;
  logic              clr_overflow;
  logic              underrun;

  modport master (
    input  enable, mic_wr, fifo_full, fifo_empty, fifo_dout, out_ready, clr_overflow,
    output fifo_rd_en, out_data, out_valid, out_sof, out_eof, busy, frame_cnt, overflow, underrun
  );

  modport slave (
    output enable, mic_wr, fifo_full, fifo_empty, fifo_dout, out_ready, clr_overflow,
    input  fifo_rd_en, out_data, out_valid, out_sof, out_eof, busy, frame_cnt, overflow, underrun
  );
endinterface

// File: rtl/mic_frame_ctrl.sv
// Purpose : read-side sequencer for the mic sample FIFO; drains whole frames of FRAME_LEN samples.
// Latency : first sample valid 3 cycles after the fill decision; steady state one sample per 3 cycles.
// Backpr. : out_valid/out_data/out_sof/out_eof held until out_ready; no FIFO read while stalled.
// Ports   : i_clk, i_rst (async, active low); bus (mic_frame_ctrl_if.master) carries all other signals.
module mic_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  mic_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FILL,
    S_READ,
    S_LOAD,
    S_PRESENT
  } state_t;

  localparam logic [CNT_W-1:0] LP_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(FRAME_LEN - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_idx;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_sof;
  logic              r_eof;
  logic              r_busy;
  logic [15:0]       r_frame_cnt;
  logic              r_ovf;
  logic              r_underrun;

  logic w_wr_acc;
  logic w_rd_acc;

  // Mirror the FIFO's own accept rules so the count tracks its true fill.
  assign w_wr_acc = bus.mic_wr & ~bus.fifo_full;
  assign w_rd_acc = r_rd_en & ~bus.fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_occ <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_occ <= r_occ + CNT_W'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      r_occ <= r_occ - CNT_W'(1);
    end
  end

  // A dropped write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ovf <= 1'b0;
    end else if (bus.mic_wr && bus.fifo_full) begin
      r_ovf <= 1'b1;
    end else if (bus.clr_overflow) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd_en     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_underrun  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable) r_state <= S_WAIT_FILL;
        end
        S_WAIT_FILL: begin
          // enable is only honoured here, so a running frame always completes.
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (r_occ >= LP_FRAME) begin
            r_state <= S_READ;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_rd_en <= 1'b1;
          end
        end
        S_READ: begin
          r_rd_en <= 1'b0;
          if (bus.fifo_empty) r_underrun <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          // FIFO output is registered: data requested in READ is present now.
          r_out_data  <= bus.fifo_dout;
          r_out_valid <= 1'b1;
          r_sof       <= (r_idx == '0);
          r_eof       <= (r_idx == LP_LAST);
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            if (r_idx == LP_LAST) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_busy      <= 1'b0;
              r_state     <= S_WAIT_FILL;
            end else begin
              r_idx   <= r_idx + CNT_W'(1);
              r_rd_en <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = r_rd_en;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sof    = r_sof;
  assign bus.out_eof    = r_eof;
  assign bus.busy       = r_busy;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.overflow   = r_ovf;
  assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// Purpose : directed bench for mic_frame_ctrl with a behavioural 127-entry FIFO and a sample scoreboard.
// Latency : checks first-sample timing, back-to-back frame gap and backpressure hold.
// Backpr. : out_ready driven by the directed sequence; outputs sampled on the falling edge.
module tb_mic_frame_ctrl;
  localparam int FL = 4;

  logic clk;
  logic rst_n;
  logic [15:0] mic_dat;

  mic_frame_ctrl_if #(.DATA_W(16)) bus ();

  mic_frame_ctrl #(.FRAME_LEN(FL), .DATA_W(16), .CNT_W(8)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: 128 slots, usable depth 127, registered read data.
  logic [15:0] mem [128];
  logic [6:0]  wp, rp;
  logic [7:0]  fifo_cnt;
  logic [15:0] fifo_dout_r;
  logic        tb_wr, tb_rd;

  assign bus.fifo_full  = (fifo_cnt == 8'd127);
  assign bus.fifo_empty = (fifo_cnt == 8'd0);
  assign bus.fifo_dout  = fifo_dout_r;
  assign tb_wr = bus.mic_wr & ~bus.fifo_full;
  assign tb_rd = bus.fifo_rd_en & ~bus.fifo_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; fifo_cnt <= '0; fifo_dout_r <= '0;
    end else begin
      if (tb_wr) begin mem[wp] <= mic_dat; wp <= wp + 7'd1; end
      if (tb_rd) begin fifo_dout_r <= mem[rp]; rp <= rp + 7'd1; end
      fifo_cnt <= fifo_cnt + 8'(tb_wr) - 8'(tb_rd);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];
  int out_idx = 0, n_acc = 0, rd_cnt = 0, cyc = 0;
  int last_eof_cyc = -1;
  bit bb_chk = 0;
  bit prev_hold = 0, prev_vld = 0, prev_sof = 0, prev_eof = 0;
  logic [15:0] prev_dat = '0;
  logic [15:0] wdat_n = 16'hA000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      out_idx = 0; prev_hold = 0; prev_vld = 0;
    end else begin
      check("occupancy", 32'(dut.r_occ), 32'(fifo_cnt));
      if (bus.fifo_rd_en) rd_cnt++;
      if (prev_hold) begin
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_data", 32'(bus.out_data), 32'(prev_dat));
        check("hold_flags", {30'd0, bus.out_sof, bus.out_eof}, {30'd0, prev_sof, prev_eof});
      end
      if (bb_chk && bus.out_valid && !prev_vld && bus.out_sof && last_eof_cyc >= 0)
        check("b2b_gap", cyc - last_eof_cyc, 4);
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        check("sb_sof", 32'(bus.out_sof), 32'(out_idx == 0));
        check("sb_eof", 32'(bus.out_eof), 32'(out_idx == FL - 1));
        if (bb_chk && bus.out_eof) last_eof_cyc = cyc;
        out_idx = (out_idx + 1) % FL;
        n_acc++;
      end
      prev_hold = bus.out_valid & ~bus.out_ready;
      prev_vld  = bus.out_valid;
      prev_dat  = bus.out_data;
      prev_sof  = bus.out_sof;
      prev_eof  = bus.out_eof;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1();
    bus.mic_wr = 1'b1;
    mic_dat = wdat_n;
    if (!bus.fifo_full) exp_q.push_back(wdat_n);
    wdat_n = wdat_n + 16'd1;
    tick();
    bus.mic_wr = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && bus.frame_cnt != 16'(target); i++) tick();
    check("frame_cnt", 32'(bus.frame_cnt), target);
  endtask

  task automatic wait_acc(input int target, input int budget);
    for (int i = 0; i < budget && n_acc != target; i++) tick();
    check("acc_cnt", n_acc, target);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {25'd0, bus.fifo_rd_en, bus.out_valid, bus.out_sof, bus.out_eof,
                          bus.busy, bus.overflow, bus.underrun}, 0);
    check({tag, "_data"}, 32'(bus.out_data), 0);
    check({tag, "_fcnt"}, 32'(bus.frame_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rd0;
    logic [15:0] d0;
    bus.enable = 0; bus.mic_wr = 0; bus.out_ready = 0; bus.clr_overflow = 0;
    mic_dat = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset with random stimulus: everything stays quiet.
    for (int i = 0; i < 6; i++) begin
      bus.enable = 1'($urandom); bus.mic_wr = 1'($urandom);
      bus.out_ready = 1'($urandom); bus.clr_overflow = 1'($urandom);
      mic_dat = 16'($urandom);
      tick();
      check_quiet("reset");
    end
    bus.enable = 0; bus.mic_wr = 0; bus.out_ready = 0; bus.clr_overflow = 0;
    tick();
    rst_n = 1'b1;

    // Threshold start.
    bus.enable = 1; bus.out_ready = 1;
    tick();
    repeat (3) begin write1(); tick(); end
    repeat (8) tick();
    check("below_thr_rd", rd_cnt, 0);
    check("below_thr_busy", 32'(bus.busy), 0);
    write1();
    tick();
    check("lat_rd_en", 32'(bus.fifo_rd_en), 1);
    tick();
    check("lat_load_vld", 32'(bus.out_valid), 0);
    tick();
    check("lat_vld", 32'(bus.out_valid), 1);
    wait_frames(1, 40);
    check("thr_rd_pulses", rd_cnt, 4);
    check("thr_acc", n_acc, 4);

    // Backpressure.
    bus.out_ready = 0;
    repeat (4) write1();
    for (int i = 0; i < 30 && !bus.out_valid; i++) tick();
    check("bp_vld_seen", 32'(bus.out_valid), 1);
    d0 = bus.out_data; rd0 = rd_cnt;
    repeat (10) begin
      tick();
      check("bp_vld", 32'(bus.out_valid), 1);
      check("bp_data", 32'(bus.out_data), 32'(d0));
    end
    check("bp_no_rd", rd_cnt, rd0);
    bus.out_ready = 1;
    wait_frames(2, 60);
    check("bp_acc", n_acc, 8);

    // Concurrent writes every 2 cycles while frames drain.
    last_eof_cyc = -1; bb_chk = 1;
    repeat (16) begin write1(); tick(); end
    wait_frames(6, 200);
    bb_chk = 0;
    check("cc_occ_empty", 32'(dut.r_occ), 0);

    // enable falls mid-frame: frame completes, then IDLE.
    base = n_acc;
    repeat (4) write1();
    wait_acc(base + 2, 40);
    bus.enable = 0;
    wait_frames(7, 40);
    tick(); tick();
    check("en_fall_acc", n_acc, base + 4);
    check("en_fall_idle", 32'(dut.r_state), 0);
    check("en_fall_busy", 32'(bus.busy), 0);

    // Overflow at a full FIFO.
    repeat (127) write1();
    check("ovf_fill_occ", 32'(dut.r_occ), 127);
    check("ovf_pre", 32'(bus.overflow), 0);
    write1();
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_occ", 32'(dut.r_occ), 127);
    bus.clr_overflow = 1;
    write1();
    bus.clr_overflow = 0;
    check("ovf_set_wins", 32'(bus.overflow), 1);
    bus.clr_overflow = 1;
    tick();
    bus.clr_overflow = 0;
    check("ovf_clr", 32'(bus.overflow), 0);

    // Reset mid-frame, then a clean restart.
    bus.enable = 1;
    base = n_acc;
    wait_acc(base + 2, 60);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_mid");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_quiet("rst_after");
    rd0 = rd_cnt; base = n_acc;
    repeat (4) write1();
    wait_frames(1, 60);
    check("restart_rd", rd_cnt - rd0, 4);
    check("restart_acc", n_acc - base, 4);
    check("no_underrun", 32'(bus.underrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mic_frame_ctrl.md
Name: mic_frame_ctrl

Overview:
- Read-side sequencer for the 128-entry x 16-bit microphone sample FIFO.
- Tracks FIFO occupancy by counting accepted writes and its own reads.
- Starts a frame only when a full frame of samples is buffered, then drains exactly FRAME_LEN samples to the downstream feature-extraction stage over a valid/ready interface.
- Flags frame boundaries, counts frames and records mic-side overflow.

Parameters:
- FRAME_LEN, 64: samples per frame. Legal range 1..127; the FIFO holds at most 127 entries.
- DATA_W, 16: sample width; matches the FIFO data width.
- CNT_W, 8: occupancy counter width; must cover 0..127.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- enable, in, 1: allows new frames to start.
- mic_wr, in, 1: mic write strobe; the same signal drives the FIFO wr_en.
- fifo_full, in, 1: FIFO full flag.
- fifo_empty, in, 1: FIFO empty flag.
- fifo_dout, in, DATA_W: FIFO read data, registered, valid the cycle after rd_en.
- fifo_rd_en, out, 1: FIFO read strobe.
- out_data, out, DATA_W: sample to downstream.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: downstream accepts.
- out_sof, out, 1: qualifies the first sample of a frame.
- out_eof, out, 1: qualifies the last sample of a frame.
- busy, out, 1: a frame is in progress.
- frame_cnt, out, 16: completed frames; wraps.
- overflow, out, 1: sticky; set when a sample is dropped at a full FIFO.
- clr_overflow, in, 1: clears overflow.
- underrun, out, 1: sticky; a read was attempted while the FIFO was empty.

Behaviour:
- Reset (rst=0, async): every output is 0, including out_data, frame_cnt and both sticky flags. Occupancy is 0, sample index is 0, state is IDLE.
- The FIFO must share rst so that its pointers and the occupancy count agree.
- Occupancy update:
  - wr_acc = mic_wr & ~fifo_full; rd_acc = fifo_rd_en & ~fifo_empty.
  - Occupancy gets +1 on wr_acc only, -1 on rd_acc only, and is unchanged when both or neither occur.
- Overflow: mic_wr & fifo_full sets overflow. clr_overflow clears it. If set and clear occur in the same cycle, set wins.
- States:
  - IDLE: outputs quiet. Go to WAIT_FILL when enable=1.
  - WAIT_FILL:
    - If enable=0, return to IDLE.
    - If occupancy >= FRAME_LEN, go to READ, set busy=1 and set sample index to 0.
    - Occupancy is compared as registered, so there is one cycle of decision latency.
  - READ: fifo_rd_en=1 for exactly one cycle, then LOAD. If fifo_empty=1 in this cycle, set underrun and still go to LOAD; the FIFO holds its previous dout.
  - LOAD:
    - Capture fifo_dout into out_data and set out_valid=1.
    - out_sof=(idx==0); out_eof=(idx==FRAME_LEN-1).
    - Go to PRESENT.
  - PRESENT:
    - Hold out_data, out_sof and out_eof stable while out_valid=1 and out_ready=0.
    - On out_valid & out_ready, drop out_valid the next cycle.
    - If this is not the last sample: idx+1, go to READ.
    - If it is the last sample: frame_cnt+1, busy=0, go to WAIT_FILL.
- Handshake:
  - out_valid, once raised, never drops until accepted.
  - out_ready may be asserted early; it is only sampled in PRESENT.
- Throughput and latency:
  - Best case is one sample per 3 cycles: READ, LOAD, PRESENT with out_ready=1.
  - The first sample of a frame appears 3 cycles after the occupancy threshold is met, counted from the WAIT_FILL decision edge.
- Frames are atomic:
  - If enable falls mid-frame, the current frame completes; then go to WAIT_FILL and on to IDLE.
  - No partial frame is ever emitted.
- The mic side keeps writing during a frame; concurrent writes and reads are legal.
- fifo_rd_en is never asserted outside READ.

Test Plan:
- Reset/idle: hold rst=0 with random inputs. All outputs stay 0, including fifo_rd_en, frame_cnt and overflow.
- Threshold start (FRAME_LEN=4, out_ready=1, enable=1):
  - Write 3 samples: no fifo_rd_en.
  - Write a 4th sample: exactly 4 rd_en pulses follow.
  - Output is 4 samples in order, with sof on the 1st and eof on the 4th; frame_cnt=1.
- Backpressure: hold out_ready=0 for 10 cycles in PRESENT. out_data stays stable, no extra fifo_rd_en is issued, and no sample is lost or duplicated.
- Concurrent write/read: stream mic_wr every 2 cycles while frames drain. The occupancy count matches the FIFO's true fill at every cycle, and frames are emitted back-to-back.
- Overflow:
  - Fill the FIFO to 127 with enable=0, then pulse mic_wr: overflow=1 and occupancy stays 127.
  - Assert clr_overflow and mic_wr together with the FIFO still full: overflow stays 1.
- Mid-operation events:
  - Deassert enable at sample 2 of 4: the frame completes, then state is IDLE.
  - Pulse rst mid-frame: all outputs go to 0 immediately, and fresh traffic restarts cleanly from frame_cnt=0.
